// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master arbiter onto one slave bus with registered strobes and acks.
// Optional read timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  m0_addr,
    input  logic         m0_ren,
    input  logic         m0_wen,
    input  logic [W-1:0] m0_wdata,
    input  logic [3:0]   m0_wmask,
    output logic [W-1:0] m0_rdata,
    output logic         m0_ack,
    input  logic [15:0]  m1_addr,
    input  logic         m1_ren,
    input  logic         m1_wen,
    input  logic [W-1:0] m1_wdata,
    input  logic [3:0]   m1_wmask,
    output logic [W-1:0] m1_rdata,
    output logic         m1_ack,
    output logic [15:0]  s_addr,
    output logic         s_ren,
    output logic         s_wen,
    output logic [W-1:0] s_wdata,
    output logic [3:0]   s_wmask,
    input  logic [W-1:0] s_rdata,
    input  logic         s_rd_valid,
    output logic         owner,
    output logic         timeout
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t       state_q;
    logic         last_q;
    logic         req0, req1, grant_d, grant_wr_d, expire_d;
    logic [W-1:0] rdata_d;

    always_comb begin
        req0       = m0_ren | m0_wen;
        req1       = m1_ren | m1_wen;
        grant_d    = (req0 & req1) ? ~last_q : req1;
        grant_wr_d = grant_d ? m1_wen : m0_wen;
        rdata_d    = s_rd_valid ? s_rdata : '0;
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;

    // Counter sits at zero outside READ, so it is already cleared on entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != READ)
            cnt_q <= '0;
        else if (!s_rd_valid)
            cnt_q <= cnt_q + 16'd1;
    end

    always_comb expire_d = (cnt_q == 16'(TIMEOUT - 1)) & ~s_rd_valid;
`else
    always_comb expire_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner    <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wmask  <= '0;
            s_ren    <= 1'b0;
            s_wen    <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req0 | req1) begin
                    owner   <= grant_d;
                    last_q  <= grant_d;
                    s_addr  <= grant_d ? m1_addr : m0_addr;
                    s_wdata <= grant_d ? m1_wdata : m0_wdata;
                    s_wmask <= grant_d ? m1_wmask : m0_wmask;
                    s_wen   <= grant_wr_d;
                    s_ren   <= ~grant_wr_d;
                    state_q <= grant_wr_d ? WRITE : READ;
                end
                WRITE: begin
                    s_wen   <= 1'b0;
                    m0_ack  <= ~owner;
                    m1_ack  <= owner;
                    state_q <= DONE;
                end
                READ: if (s_rd_valid | expire_d) begin
                    s_ren   <= 1'b0;
                    m0_ack  <= ~owner;
                    m1_ack  <= owner;
                    timeout <= expire_d;
                    if (owner)
                        m1_rdata <= rdata_d;
                    else
                        m0_rdata <= rdata_d;
                    state_q <= DONE;
                end
                DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    timeout <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter grants, strobes, acks, fairness and reset.
module tb_bus_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  m0_addr = '0, m1_addr = '0;
    logic         m0_ren = 1'b0, m0_wen = 1'b0, m1_ren = 1'b0, m1_wen = 1'b0;
    logic [W-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]   m0_wmask = '0, m1_wmask = '0;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic         m0_ack, m1_ack;
    logic [15:0]  s_addr;
    logic         s_ren, s_wen;
    logic [W-1:0] s_wdata;
    logic [3:0]   s_wmask;
    logic [W-1:0] s_rdata = '0;
    logic         s_rd_valid = 1'b0;
    logic         owner, timeout;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.W(W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_addr(s_addr), .s_ren(s_ren), .s_wen(s_wen), .s_wdata(s_wdata),
        .s_wmask(s_wmask), .s_rdata(s_rdata), .s_rd_valid(s_rd_valid),
        .owner(owner), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, n, cnt;
        tick();
        tick();
        chk("rst_s_ren", s_ren, 0);
        chk("rst_s_wen", s_wen, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_owner", owner, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;

        // single write from m0
        m0_wen = 1'b1; m0_addr = 16'h4004; m0_wdata = 32'h0000_00A5; m0_wmask = 4'hF;
        tick();
        chk("wr_s_wen", s_wen, 1);
        chk("wr_s_ren", s_ren, 0);
        chk("wr_s_addr", s_addr, 32'h4004);
        chk("wr_s_wdata", s_wdata, 32'hA5);
        chk("wr_s_wmask", s_wmask, 4'hF);
        chk("wr_ack_early", m0_ack, 0);
        chk("wr_owner", owner, 0);
        tick();
        chk("wr_s_wen_off", s_wen, 0);
        chk("wr_m0_ack", m0_ack, 1);
        chk("wr_m1_ack", m1_ack, 0);
        m0_wen = 1'b0;
        tick();
        chk("wr_ack_pulse", m0_ack, 0);

        // m1 read, slave latency 1
        m1_ren = 1'b1; m1_addr = 16'h8010;
        tick();
        chk("rd_s_ren0", s_ren, 1);
        chk("rd_owner", owner, 1);
        chk("rd_s_addr", s_addr, 32'h8010);
        tick();
        chk("rd_s_ren1", s_ren, 1);
        chk("rd_ack_early", m1_ack, 0);
        s_rd_valid = 1'b1; s_rdata = 32'h1234_5678;
        tick();
        chk("rd_m1_ack", m1_ack, 1);
        chk("rd_m1_rdata", m1_rdata, 32'h1234_5678);
        chk("rd_s_ren_off", s_ren, 0);
        chk("rd_m0_ack", m0_ack, 0);
        chk("rd_timeout", timeout, 0);
        s_rd_valid = 1'b0; s_rdata = 32'hFFFF_FFFF; m1_ren = 1'b0;
        tick();
        chk("rd_hold", m1_rdata, 32'h1234_5678);
        chk("rd_ack_pulse", m1_ack, 0);

        // simultaneous reads right after reset: m0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_ren = 1'b1; m0_addr = 16'h1000; m1_ren = 1'b1; m1_addr = 16'h2000;
        tick();
        chk("tie_owner0", owner, 0);
        chk("tie_addr0", s_addr, 32'h1000);
        s_rd_valid = 1'b1; s_rdata = 32'hAAAA_0000;
        tick();
        chk("tie_m0_ack", m0_ack, 1);
        chk("tie_m0_rdata", m0_rdata, 32'hAAAA_0000);
        chk("tie_m1_ack", m1_ack, 0);
        s_rd_valid = 1'b0; m0_ren = 1'b0;
        tick();
        tick();
        chk("tie_owner1", owner, 1);
        chk("tie_addr1", s_addr, 32'h2000);
        chk("tie_s_ren1", s_ren, 1);
        s_rd_valid = 1'b1; s_rdata = 32'hBBBB_1111;
        tick();
        chk("tie_m1_ack", m1_ack, 1);
        chk("tie_m1_rdata", m1_rdata, 32'hBBBB_1111);
        chk("tie_m0_hold", m0_rdata, 32'hAAAA_0000);
        s_rd_valid = 1'b0; m1_ren = 1'b0;
        tick();

        // constant write contention: strict alternation, 3 cycles apart
        m0_wen = 1'b1; m1_wen = 1'b1;
        prev = 0; n = 0;
        for (int c = 1; c <= 60 && n < 12; c++) begin
            tick();
            if (m0_ack | m1_ack) begin
                chk("fair_both", {m0_ack, m1_ack}, (n % 2) ? 2'b01 : 2'b10);
                if (n > 0) chk("fair_gap", c - prev, 3);
                prev = c;
                n++;
            end
        end
        chk("fair_count", n, 12);
        m0_wen = 1'b0; m1_wen = 1'b0;
        tick();
        tick();

        // reset in the middle of an unanswered read
        m0_ren = 1'b1; m0_addr = 16'h3000;
        tick();
        tick();
        tick();
        chk("abort_s_ren", s_ren, 1);
        rst = 1'b1; m0_ren = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_s_ren_off", s_ren, 0);
        chk("abort_acks", {m0_ack, m1_ack}, 0);
        chk("abort_s_addr", s_addr, 0);
        chk("abort_m0_rdata", m0_rdata, 0);
        chk("abort_m1_rdata", m1_rdata, 0);
        chk("abort_owner", owner, 0);
        tick();
        chk("abort_no_ack", {m0_ack, m1_ack}, 0);
        chk("abort_idle", {s_ren, s_wen}, 0);
        m0_wen = 1'b1; m1_wen = 1'b1; m0_addr = 16'h0044; m1_addr = 16'h0088;
        tick();
        chk("abort_tie_owner", owner, 0);
        chk("abort_tie_addr", s_addr, 32'h0044);
        tick();
        chk("abort_tie_ack", m0_ack, 1);
        m0_wen = 1'b0; m1_wen = 1'b0;
        tick();
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // give m0_rdata a nonzero value, then let a read time out
        m0_ren = 1'b1; m0_addr = 16'h5000;
        tick();
        s_rd_valid = 1'b1; s_rdata = 32'h0000_0055;
        tick();
        chk("to_pre_rdata", m0_rdata, 32'h55);
        s_rd_valid = 1'b0; m0_ren = 1'b0;
        tick();
        m0_ren = 1'b1;
        cnt = 0; n = 0;
        for (int c = 0; c < 30 && n == 0; c++) begin
            tick();
            if (s_ren) cnt++;
            if (m0_ack) begin
                n = 1;
                chk("to_timeout", timeout, 1);
                chk("to_rdata", m0_rdata, 0);
            end
        end
        chk("to_seen_ack", n, 1);
        chk("to_ren_cycles", cnt, 8);
        m0_ren = 1'b0;
        tick();
        chk("to_pulse", timeout, 0);
`else
        chk("no_timeout", timeout, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
